score_display_reader: RTL

Read-side client of the score glyph ROM. It converts a binary score to four BCD digits with a sequential double-dabble engine and walks the VGA pixel stream to issue glyph addresses to the synchronous-read score ROM. It re-aligns the returned 12-bit pixels and drives an overlay colour plus an on/transparent flag to the pixel mixer. It sits between game logic (score source), the VGA sync generator (pixel coordinates) and the score ROM (10 glyphs '0'–'9', each 5×10 pixels, 50 words per glyph, 500 words total).

---
 rtl/score_display_reader.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/score_display_reader.sv
// Score overlay: double-dabble BCD converter plus a pixel pipeline that fetches
// 2x-scaled glyphs from a synchronous score ROM and emits an overlay colour.
module score_display_reader #(
  parameter logic [9:0]  POS_X       = 10'd560,
  parameter logic [9:0]  POS_Y       = 10'd16,
  parameter int unsigned ADDR_WIDTH  = 9,
  parameter int unsigned DATA_WIDTH  = 12,
  parameter logic [DATA_WIDTH-1:0] TRANSPARENT = 12'h0F0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [13:0]           score_in,
  input  logic                  score_load,
  output logic                  busy,
  input  logic [9:0]            pixel_x,
  input  logic [9:0]            pixel_y,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  score_on,
  output logic [DATA_WIDTH-1:0] score_rgb
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e      state_q;
  logic [13:0] bin_q;
  logic [15:0] bcd_q;
  logic [3:0]  cnt_q;
  logic [15:0] digits_q;
  logic        busy_q;

  logic [13:0] score_sat;
  logic [15:0] bcd_adj;
  logic [15:0] bcd_next;
  logic [13:0] bin_next;

  assign score_sat = (score_in > 14'd9999) ? 14'd9999 : score_in;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_next = {bcd_adj[14:0], bin_q[13]};
    bin_next = {bin_q[12:0], 1'b0};
  end

  // busy stays high through the cycle after DONE so the caller sees a 16-cycle window
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      digits_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          busy_q <= 1'b0;
          if (score_load) begin
            bin_q   <= score_sat;
            bcd_q   <= '0;
            cnt_q   <= 4'd14;
            busy_q  <= 1'b1;
            state_q <= StShift;
          end
        end
        StShift: begin
          bcd_q <= bcd_next;
          bin_q <= bin_next;
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= StDone;
        end
        StDone: begin
          digits_q <= bcd_q;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = busy_q;

  logic [9:0]            dx;
  logic [9:0]            dy;
  logic                  hit;
  logic [5:0]            dx6;
  logic [5:0]            rem6;
  logic [1:0]            slot;
  logic [3:0]            glyph;
  logic [2:0]            col;
  logic [3:0]            row;
  logic [ADDR_WIDTH-1:0] glyph_w;
  logic [ADDR_WIDTH-1:0] row_w;
  logic [ADDR_WIDTH-1:0] addr;

  assign dx  = pixel_x - POS_X;
  assign dy  = pixel_y - POS_Y;
  assign hit = ({1'b0, pixel_x} >= {1'b0, POS_X}) && ({1'b0, pixel_x} < {1'b0, POS_X} + 11'd40) &&
               ({1'b0, pixel_y} >= {1'b0, POS_Y}) && ({1'b0, pixel_y} < {1'b0, POS_Y} + 11'd20);

  // Slot and in-glyph column from range compares instead of a divide by 10
  always_comb begin
    dx6 = dx[5:0];
    if (dx6 < 6'd10) begin
      slot = 2'd0;
      rem6 = dx6;
    end else if (dx6 < 6'd20) begin
      slot = 2'd1;
      rem6 = dx6 - 6'd10;
    end else if (dx6 < 6'd30) begin
      slot = 2'd2;
      rem6 = dx6 - 6'd20;
    end else begin
      slot = 2'd3;
      rem6 = dx6 - 6'd30;
    end
    col = rem6[3:1];
    row = dy[4:1];
    case (slot)
      2'd0:    glyph = digits_q[15:12];
      2'd1:    glyph = digits_q[11:8];
      2'd2:    glyph = digits_q[7:4];
      default: glyph = digits_q[3:0];
    endcase
    glyph_w = ADDR_WIDTH'(glyph);
    row_w   = ADDR_WIDTH'(row);
    // glyph*50 = 32g + 16g + 2g, row*5 = 4r + r
    addr = (glyph_w << 5) + (glyph_w << 4) + (glyph_w << 1) + (row_w << 2) + row_w +
           ADDR_WIDTH'(col);
  end

  logic unused_bits;
  assign unused_bits = ^{dx[9:6], dy[9:5], dy[0], rem6[5:4], rem6[0]};

  logic hit_d1;
  logic hit_d2;
  logic pix_on;

  assign pix_on = hit_d2 && (rom_data != TRANSPARENT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr  <= '0;
      hit_d1    <= 1'b0;
      hit_d2    <= 1'b0;
      score_on  <= 1'b0;
      score_rgb <= '0;
    end else begin
      rom_addr  <= hit ? addr : '0;
      hit_d1    <= hit;
      hit_d2    <= hit_d1;
      score_on  <= pix_on;
      score_rgb <= pix_on ? rom_data : '0;
    end
  end

endmodule
